// File: rtl/modulo_unit.sv
// -----------------------------------------------------------------------------
// modulo_unit
//   Iterative remainder unit. It answers the modulo_start/modulo_ready
//   handshake of the GCD controller. It computes A mod B and A / B by
//   restoring binary long division, producing one quotient bit per clock.
//
// Parameters
//   WIDTH           operand, remainder and quotient width (>= 2)
//
// Ports
//   clk             system clock; all state changes on the rising edge
//   rst_i           synchronous, active-high reset
//   modulo_start_i  level request; the initiator holds it high until it
//                   sees modulo_ready_o
//   zahl_a_i        dividend A; sampled only on the accepting edge
//   zahl_b_i        divisor B; sampled only on the accepting edge
//   modulo_ready_o  one-cycle completion pulse
//   rest_o          remainder A mod B; held until the next completion
//   quotient_o      quotient A / B; held until the next completion
//   div_by_zero_o   set when the last completed operation had B == 0
//   busy_o          high while calculating and in the completion cycle
// -----------------------------------------------------------------------------
module modulo_unit #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_i,
  input  logic             modulo_start_i,
  input  logic [WIDTH-1:0] zahl_a_i,
  input  logic [WIDTH-1:0] zahl_b_i,
  output logic             modulo_ready_o,
  output logic [WIDTH-1:0] rest_o,
  output logic [WIDTH-1:0] quotient_o,
  output logic             div_by_zero_o,
  output logic             busy_o
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_DONE,
    S_RELEASE
  } state_t;

  state_t           state_q;
  state_t           state_d;

  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] divisor;
  logic [WIDTH-1:0] rem;
  logic [CW-1:0]    cnt;

  logic [WIDTH:0]   r_ext;
  logic             q_bit;
  logic [WIDTH-1:0] rem_next;
  logic [WIDTH-1:0] a_next;

  // One restoring-division step. The trial remainder is kept one bit wider
  // than the operands so that r' >= B and r' - B never overflow, even for
  // a divisor of 2^WIDTH-1; the result is always below B and fits WIDTH.
  always_comb begin
    r_ext    = {rem, a_sh[WIDTH-1]};
    q_bit    = (r_ext >= {1'b0, divisor});
    rem_next = q_bit ? WIDTH'(r_ext - {1'b0, divisor}) : r_ext[WIDTH-1:0];
    a_next   = {a_sh[WIDTH-2:0], q_bit};
  end

  always_ff @(posedge clk) begin
    if (rst_i) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Dropping start while calculating aborts without a ready pulse. After a
  // completion the unit parks in RELEASE until start goes low, so a start
  // that is held high never triggers a second operation.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (modulo_start_i) begin
          state_d = (zahl_b_i == '0) ? S_DONE : S_CALC;
        end
      end
      S_CALC: begin
        if (!modulo_start_i) begin
          state_d = S_IDLE;
        end else if (cnt == '0) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = modulo_start_i ? S_RELEASE : S_IDLE;
      end
      S_RELEASE: begin
        if (!modulo_start_i) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // The dividend shift register turns into the quotient as the quotient bits
  // shift in from the right. Results load on the same edge that enters DONE,
  // so they are already valid during the ready pulse. A zero divisor skips
  // the loop and reports A as the remainder.
  always_ff @(posedge clk) begin
    if (rst_i) begin
      a_sh          <= '0;
      divisor       <= '0;
      rem           <= '0;
      cnt           <= '0;
      rest_o        <= '0;
      quotient_o    <= '0;
      div_by_zero_o <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (modulo_start_i) begin
            a_sh    <= zahl_a_i;
            divisor <= zahl_b_i;
            rem     <= '0;
            cnt     <= CW'(WIDTH - 1);
            if (zahl_b_i == '0) begin
              rest_o        <= zahl_a_i;
              quotient_o    <= '0;
              div_by_zero_o <= 1'b1;
            end
          end
        end
        S_CALC: begin
          if (modulo_start_i) begin
            a_sh <= a_next;
            rem  <= rem_next;
            cnt  <= cnt - 1'b1;
            if (cnt == '0) begin
              rest_o        <= rem_next;
              quotient_o    <= a_next;
              div_by_zero_o <= 1'b0;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign modulo_ready_o = (state_q == S_DONE);
  assign busy_o         = (state_q == S_CALC) || (state_q == S_DONE);

endmodule
